// File: rtl/sram_emu_pkg.sv
// Shared types and constants for the on-chip SRAM responder emulator.
//   state_t : responder FSM states
//   fault_t : fault-injection modes selected by fault_sel
//   READ_LAT, DATA_W, EXT_ADDR_W : interface constants of the emulated SRAM
package sram_emu_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        F_NONE  = 2'b00,
        F_STUCK = 2'b01,
        F_ALIAS = 2'b10,
        F_DROP  = 2'b11
    } fault_t;

    localparam int READ_LAT   = 2;
    localparam int DATA_W     = 16;
    localparam int EXT_ADDR_W = 18;

endpackage

// File: rtl/sram_emu_mem.sv
// Single-port 2**ADDR_W x DATA_W array with write-first registered read.
//   clk, rst_n : clock, async active-low reset (read path only; array keeps contents)
//   en         : this cycle is a valid access; otherwise the read path loads 0
//   we         : write enable (already gated by en and any fault logic)
//   addr, wdata: access address and write data
//   rdata      : stage-1 read data, registered array output
module sram_emu_mem
    import sram_emu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr_q;
    logic              vld_q;

    // Array has no reset so contents survive Resetn.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // addr_q is the synchronous read port of the array. Because the array is
    // read from the registered address after the write has landed, a write
    // and a read of the same address on the same edge return the new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            vld_q  <= 1'b0;
            rdata  <= '0;
        end else begin
            addr_q <= addr;
            vld_q  <= en;
            rdata  <= vld_q ? mem[addr_q] : '0;
        end
    end

endmodule

// File: rtl/sram_responder_emu.sv
// On-chip stand-in for the external SRAM + controller (responder side).
// Models the power-up ready delay, the read pipeline and latched faults.
//   Clock_50, Resetn        : clock, async active-low reset
//   SRAM_address            : access address (only [ADDR_W-1:0] used, aliases)
//   SRAM_write_data, SRAM_we_n : write data, active-low write enable
//   SRAM_read_data          : read data, 2 edges after the address is sampled
//   SRAM_ready              : interface usable
//   fault_sel               : fault mode, latched when the interface becomes ready
//   write_count             : accepted writes since reset, saturating
module sram_responder_emu
    import sram_emu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int INIT_CYCLES = 16,
    parameter int STUCK_BIT   = 15
) (
    input  logic                  Clock_50,
    input  logic                  Resetn,
    input  logic [EXT_ADDR_W-1:0] SRAM_address,
    input  logic [DATA_W-1:0]     SRAM_write_data,
    input  logic                  SRAM_we_n,
    output logic [DATA_W-1:0]     SRAM_read_data,
    output logic                  SRAM_ready,
    input  logic [1:0]            fault_sel,
    output logic [15:0]           write_count
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [DATA_W-1:0] STUCK_MASK = ~(DATA_W'(1) << STUCK_BIT);

    state_t            state;
    logic [CNT_W-1:0]  init_cnt;
    logic              ready_q;
    fault_t            fault_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] stage1;

    logic              access;
    logic              wr;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_raw;
    logic [ADDR_W-1:0] mem_addr;
    logic              unused_addr;

    // FSM, init counter, registered ready and the fault latch.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_RESET;
            init_cnt <= '0;
            ready_q  <= 1'b0;
            fault_q  <= F_NONE;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_INIT;
                    init_cnt <= '0;
                end
                S_INIT: begin
                    if (init_cnt == CNT_W'(INIT_CYCLES - 1)) begin
                        state   <= S_READY;
                        ready_q <= 1'b1;
                        fault_q <= fault_t'(fault_sel);
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign access      = (state == S_READY);
    assign wr          = access && !SRAM_we_n;
    assign addr_raw    = SRAM_address[ADDR_W-1:0];
    assign unused_addr = ^SRAM_address[EXT_ADDR_W-1:ADDR_W];

    // Alias fault remaps only write cycles; the same-cycle read follows the
    // remapped address so write-first returns what was actually stored.
    assign mem_addr = (wr && fault_q == F_ALIAS) ? (addr_raw & ~ADDR_W'(1)) : addr_raw;
    assign mem_we   = wr && (fault_q != F_DROP);

    sram_emu_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (Clock_50),
        .rst_n (Resetn),
        .en    (access),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (SRAM_write_data),
        .rdata (stage1)
    );

    // Stage 2 applies the stuck-bit mask; write_count counts dropped writes too.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            rd_q        <= '0;
            write_count <= '0;
        end else begin
            rd_q <= (fault_q == F_STUCK) ? (stage1 & STUCK_MASK) : stage1;
            if (wr && write_count != 16'hFFFF) write_count <= write_count + 16'd1;
        end
    end

    assign SRAM_read_data = rd_q;
    assign SRAM_ready     = ready_q;

endmodule

// File: tb/tb_sram_responder_emu.sv
module tb_sram_responder_emu;

    logic        Clock_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        SRAM_ready;
    logic [1:0]  fault_sel;
    logic [15:0] write_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clock_50 = ~Clock_50;

    sram_responder_emu #(
        .ADDR_W      (8),
        .INIT_CYCLES (16),
        .STUCK_BIT   (15)
    ) dut (
        .Clock_50        (Clock_50),
        .Resetn          (Resetn),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_ready      (SRAM_ready),
        .fault_sel       (fault_sel),
        .write_count     (write_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, land 1 time unit after it.
    task automatic step();
        @(posedge Clock_50);
        #1;
    endtask

    // One access sampled at the next edge, then back to reading the same address.
    task automatic acc(input logic we_n, input logic [17:0] a, input logic [15:0] d);
        SRAM_we_n       = we_n;
        SRAM_address    = a;
        SRAM_write_data = d;
        step();
        SRAM_we_n = 1'b1;
    endtask

    // Read sampled at edge k, data checked just after edge k+2.
    task automatic rd_chk(input string tag, input logic [17:0] a, input logic [15:0] exp);
        SRAM_we_n    = 1'b1;
        SRAM_address = a;
        step();
        step();
        step();
        chk(tag, SRAM_read_data, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!SRAM_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_latency", n, 17);
        chk("ready_rd_zero", SRAM_read_data, 16'h0000);
    endtask

    // Called just after an edge; reset pulse stays between edges.
    task automatic do_reset(input logic [1:0] f);
        Resetn    = 1'b0;
        SRAM_we_n = 1'b1;
        #1;
        chk("rst_async_rd", SRAM_read_data, 16'h0000);
        chk("rst_async_ready", SRAM_ready, 1'b0);
        chk("rst_wc", write_count, 16'h0000);
        #1;
        fault_sel = f;
        Resetn    = 1'b1;
        wait_ready();
    endtask

    initial begin
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        fault_sel       = 2'b00;
        step();
        step();
        chk("rst_ready", SRAM_ready, 1'b0);
        chk("rst_rd", SRAM_read_data, 16'h0000);
        chk("rst_wc", write_count, 16'h0000);

        // Release between edges; ready must appear right after the 17th edge.
        #2 Resetn = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("init_ready_e%0d", e), SRAM_ready, 1'b0);
            chk($sformatf("init_rd_e%0d", e), SRAM_read_data, 16'h0000);
        end
        step();
        chk("ready_e17", SRAM_ready, 1'b1);
        chk("ready_e17_rd", SRAM_read_data, 16'h0000);

        // Write then read on the next cycle (edges 18, 19).
        acc(1'b0, 18'h00010, 16'hA5A5);
        acc(1'b1, 18'h00010, 16'h0000);
        chk("rd_not_yet", SRAM_read_data, 16'h0000);
        step();
        chk("wr_own_read", SRAM_read_data, 16'hA5A5);
        step();
        chk("rd_a5a5", SRAM_read_data, 16'hA5A5);
        chk("wc_1", write_count, 16'd1);

        // Same-cycle write/read (edge 22): old data for two more edges, then new.
        acc(1'b0, 18'h00020, 16'h1234);
        chk("wf_pre1", SRAM_read_data, 16'hA5A5);
        step();
        chk("wf_pre2", SRAM_read_data, 16'hA5A5);
        step();
        chk("wf_1234", SRAM_read_data, 16'h1234);
        chk("wc_2", write_count, 16'd2);

        // High address bits ignored.
        acc(1'b0, 18'h00105, 16'hBEEF);
        rd_chk("alias_addr", 18'h00005, 16'hBEEF);
        chk("wc_3", write_count, 16'd3);

        // Seed locations for later fault tests, then reset with a read in flight.
        acc(1'b0, 18'h00002, 16'h0000);
        acc(1'b0, 18'h00000, 16'hCCCC);
        acc(1'b1, 18'h00020, 16'h0000);
        step();
        chk("pre_rst_rd", SRAM_read_data, 16'hCCCC);
        chk("wc_5", write_count, 16'd5);
        do_reset(2'b00);
        rd_chk("persist_20", 18'h00020, 16'h1234);
        rd_chk("persist_10", 18'h00010, 16'hA5A5);

        // Stuck bit 15; fault_sel change after ready has no effect.
        do_reset(2'b01);
        fault_sel = 2'b11;
        acc(1'b0, 18'h00003, 16'hFFFF);
        rd_chk("stuck_ffff", 18'h00003, 16'h7FFF);
        rd_chk("stuck_old", 18'h00010, 16'h25A5);
        chk("stuck_wc", write_count, 16'd1);

        // Write-LSB alias: write @1 lands at 0.
        do_reset(2'b10);
        fault_sel = 2'b00;
        acc(1'b0, 18'h00001, 16'h0001);
        rd_chk("alias_fault", 18'h00000, 16'h0001);
        chk("alias_wc", write_count, 16'd1);

        // Dropped writes still count; then saturate the counter.
        do_reset(2'b11);
        fault_sel = 2'b00;
        acc(1'b0, 18'h00002, 16'h5555);
        rd_chk("drop", 18'h00002, 16'h0000);
        chk("drop_wc", write_count, 16'd1);
        SRAM_we_n = 1'b0;
        repeat (65534) step();
        chk("wc_sat", write_count, 16'hFFFF);
        step();
        chk("wc_sat_hold", write_count, 16'hFFFF);
        SRAM_we_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
